mem_access_ctrl: RTL and testbench

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 37 +++
 rtl/load_align.sv | 26 ++
 rtl/mem_access_ctrl.sv | 116 +++++++++++
 tb/tb_mem_access_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared bus widths, access size codes and controller state encoding.
// Imported by the memory access controller and its load aligner.
package mem_access_ctrl_pkg;

  localparam int MEM_SEL_BUS = 4;
  localparam int DATA_BUS    = 32;

  localparam logic [MEM_SEL_BUS-1:0] SEL_BYTE = 4'b0001;
  localparam logic [MEM_SEL_BUS-1:0] SEL_HALF = 4'b0011;
  localparam logic [MEM_SEL_BUS-1:0] SEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic sel_legal(
    input logic [MEM_SEL_BUS-1:0] sel
  );
    return (sel == SEL_BYTE) ||
           (sel == SEL_HALF) ||
           (sel == SEL_WORD);
  endfunction

  function automatic logic addr_aligned(
    input logic [MEM_SEL_BUS-1:0] sel,
    input logic [1:0]             off
  );
    logic ok;
    ok = 1'b1;
    if (sel == SEL_HALF) ok = ~off[0];
    if (sel == SEL_WORD) ok = (off == 2'b00);
    return ok;
  endfunction

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half lane out of a read word and
// sign- or zero-extends it to the full data width.
module load_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [DATA_BUS-1:0]    rdata_i,
  input  logic [MEM_SEL_BUS-1:0] size_i,
  input  logic [1:0]             off_i,
  input  logic                   sign_i,
  output logic [DATA_BUS-1:0]    data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = rdata_i[{off_i, 3'b000} +: 8];
    half_v = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SEL_BYTE: data_o = {{24{sign_i & byte_v[7]}}, byte_v};
      SEL_HALF: data_o = {{16{sign_i & half_v[15]}}, half_v};
      default:  data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store unit bus controller: issues one bus access per legal
// request, stalls the pipeline until completion, formats loads.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_read_flag,
  input  logic                   mem_write_flag,
  input  logic                   mem_sign_ext_flag,
  input  logic [MEM_SEL_BUS-1:0] mem_sel,
  input  logic [DATA_BUS-1:0]    mem_write_data,
  input  logic [DATA_BUS-1:0]    mem_addr,
  output logic                   ram_en,
  output logic [MEM_SEL_BUS-1:0] ram_write_en,
  output logic [DATA_BUS-1:0]    ram_addr,
  output logic [DATA_BUS-1:0]    ram_write_data,
  input  logic                   ram_ready,
  input  logic [DATA_BUS-1:0]    ram_read_data,
  output logic [DATA_BUS-1:0]    load_data,
  output logic                   stall_request,
  output logic                   addr_error
);

  state_e                 state_q;
  logic                   ram_en_q;
  logic [MEM_SEL_BUS-1:0] we_q;
  logic [DATA_BUS-1:0]    addr_q;
  logic [DATA_BUS-1:0]    wdata_q;
  logic [MEM_SEL_BUS-1:0] size_q;
  logic [1:0]             off_q;
  logic                   sign_q;
  logic                   is_ld_q;
  logic [DATA_BUS-1:0]    load_q;

  logic                   req_v;
  logic                   mis;
  logic                   go;
  logic [MEM_SEL_BUS-1:0] strb_d;
  logic [DATA_BUS-1:0]    wdata_d;
  logic [DATA_BUS-1:0]    fmt_data;

  assign req_v = (mem_read_flag | mem_write_flag) & sel_legal(mem_sel);
  assign mis   = req_v & ~addr_aligned(mem_sel, mem_addr[1:0]);
  assign go    = req_v & ~mis;

  always_comb begin
    strb_d = mem_sel << mem_addr[1:0];
    case (mem_sel)
      SEL_BYTE: wdata_d = {4{mem_write_data[7:0]}};
      SEL_HALF: wdata_d = {2{mem_write_data[15:0]}};
      default:  wdata_d = mem_write_data;
    endcase
  end

  load_align u_load_align (
    .rdata_i (ram_read_data),
    .size_i  (size_q),
    .off_i   (off_q),
    .sign_i  (sign_q),
    .data_o  (fmt_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ram_en_q <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      off_q    <= '0;
      sign_q   <= 1'b0;
      is_ld_q  <= 1'b0;
      load_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q  <= S_WAIT;
            ram_en_q <= 1'b1;
            addr_q   <= {mem_addr[31:2], 2'b00};
            we_q     <= mem_read_flag ? '0 : strb_d;
            wdata_q  <= wdata_d;
            size_q   <= mem_sel;
            off_q    <= mem_addr[1:0];
            sign_q   <= mem_sign_ext_flag;
            is_ld_q  <= mem_read_flag;
          end
        end
        S_WAIT: begin
          if (ram_ready) begin
            state_q  <= S_DONE;
            ram_en_q <= 1'b0;
            we_q     <= '0;
            if (is_ld_q) load_q <= fmt_data;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Reset gating keeps these combinational flags low while rst is held.
  assign stall_request = ~rst &
    (((state_q == S_IDLE) & go) | (state_q == S_WAIT));
  assign addr_error    = ~rst & (state_q == S_IDLE) & mis;

  assign ram_en         = ram_en_q;
  assign ram_write_en   = we_q;
  assign ram_addr       = addr_q;
  assign ram_write_data = wdata_q;
  assign load_data      = load_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_flag;
  logic        mem_write_flag;
  logic        mem_sign_ext_flag;
  logic [3:0]  mem_sel;
  logic [31:0] mem_write_data;
  logic [31:0] mem_addr;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_write_data;
  logic        ram_ready;
  logic [31:0] ram_read_data;
  logic [31:0] load_data;
  logic        stall_request;
  logic        addr_error;

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  logic en_prev = 1'b0;

  mem_access_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .mem_read_flag     (mem_read_flag),
    .mem_write_flag    (mem_write_flag),
    .mem_sign_ext_flag (mem_sign_ext_flag),
    .mem_sel           (mem_sel),
    .mem_write_data    (mem_write_data),
    .mem_addr          (mem_addr),
    .ram_en            (ram_en),
    .ram_write_en      (ram_write_en),
    .ram_addr          (ram_addr),
    .ram_write_data    (ram_write_data),
    .ram_ready         (ram_ready),
    .ram_read_data     (ram_read_data),
    .load_data         (load_data),
    .stall_request     (stall_request),
    .addr_error        (addr_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ram_en && !en_prev) pulses++;
    en_prev = ram_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_read_flag     = 1'b0;
    mem_write_flag    = 1'b0;
    mem_sign_ext_flag = 1'b0;
    mem_sel           = 4'b0000;
    mem_write_data    = 32'h0;
    mem_addr          = 32'h0;
    ram_ready         = 1'b0;
  endtask

  // One full access; ram_ready is raised in WAIT cycle number `waits`.
  task automatic access(
    input  logic        ld,
    input  logic [31:0] a,
    input  logic [3:0]  sel,
    input  logic        sg,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    input  int          waits,
    output int          stalls,
    output logic [31:0] a_seen,
    output logic [3:0]  we_seen,
    output logic [31:0] wd_seen
  );
    mem_read_flag     = ld;
    mem_write_flag    = ~ld;
    mem_sign_ext_flag = sg;
    mem_sel           = sel;
    mem_write_data    = wd;
    mem_addr          = a;
    ram_read_data     = rd;
    #1;
    stalls = int'(stall_request);
    a_seen = 32'h0;
    we_seen = 4'h0;
    wd_seen = 32'h0;
    for (int i = 1; i <= waits; i++) begin
      tick();
      if (i == 1) begin
        a_seen  = ram_addr;
        we_seen = ram_write_en;
        wd_seen = ram_write_data;
      end
      chk("wait_ram_en", {31'd0, ram_en}, 32'd1);
      stalls += int'(stall_request);
      if (i == waits) ram_ready = 1'b1;
    end
    tick();
    ram_ready = 1'b0;
    chk("done_ram_en", {31'd0, ram_en}, 32'd0);
    chk("done_stall", {31'd0, stall_request}, 32'd0);
    idle_inputs();
    tick();
  endtask

  int          st;
  int          p0;
  logic [31:0] a_s;
  logic [3:0]  we_s;
  logic [31:0] wd_s;

  initial begin
    idle_inputs();
    ram_read_data = 32'h0;
    rst = 1'b1;
    #12;
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_we", {28'd0, ram_write_en}, 32'd0);
    chk("rst_addr", ram_addr, 32'd0);
    chk("rst_wdata", ram_write_data, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_stall", {31'd0, stall_request}, 32'd0);
    chk("rst_err", {31'd0, addr_error}, 32'd0);
    rst = 1'b0;
    tick();

    ram_ready = 1'b1;
    tick();
    ram_ready = 1'b0;
    chk("stray_ready_en", {31'd0, ram_en}, 32'd0);
    chk("stray_ready_stall", {31'd0, stall_request}, 32'd0);

    access(1'b0, 32'h1003, 4'b0001, 1'b0, 32'h000000A5, 32'h0, 2,
           st, a_s, we_s, wd_s);
    chk("sb_addr", a_s, 32'h1000);
    chk("sb_we", {28'd0, we_s}, 32'h8);
    chk("sb_data", wd_s, 32'hA5A5A5A5);
    chk("sb_stalls", st, 32'd3);
    chk("sb_load_kept", load_data, 32'h0);

    access(1'b1, 32'h2001, 4'b0001, 1'b1, 32'h0, 32'h1234F678, 3,
           st, a_s, we_s, wd_s);
    chk("lb_load", load_data, 32'hFFFFFFF6);
    chk("lb_stalls", st, 32'd4);
    chk("lb_addr", a_s, 32'h2000);
    chk("lb_we", {28'd0, we_s}, 32'h0);

    access(1'b1, 32'h2001, 4'b0001, 1'b0, 32'h0, 32'h1234F678, 3,
           st, a_s, we_s, wd_s);
    chk("lbu_load", load_data, 32'h000000F6);

    access(1'b1, 32'h2002, 4'b0011, 1'b1, 32'h0, 32'h80010000, 1,
           st, a_s, we_s, wd_s);
    chk("lh_load", load_data, 32'hFFFF8001);
    chk("lh_stalls", st, 32'd2);

    access(1'b0, 32'h3006, 4'b0011, 1'b0, 32'h0000BEEF, 32'h0, 1,
           st, a_s, we_s, wd_s);
    chk("sh_addr", a_s, 32'h3004);
    chk("sh_we", {28'd0, we_s}, 32'hC);
    chk("sh_data", wd_s, 32'hBEEFBEEF);
    chk("sh_load_kept", load_data, 32'hFFFF8001);

    p0 = pulses;
    mem_write_flag = 1'b1;
    mem_sel        = 4'b1111;
    mem_addr       = 32'h3002;
    mem_write_data = 32'h11223344;
    #1;
    chk("mis_err", {31'd0, addr_error}, 32'd1);
    chk("mis_stall", {31'd0, stall_request}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mis_ram_en", {31'd0, ram_en}, 32'd0);
    end
    chk("mis_pulses", pulses - p0, 32'd0);
    chk("mis_load_kept", load_data, 32'hFFFF8001);
    idle_inputs();
    #1;
    chk("mis_err_clear", {31'd0, addr_error}, 32'd0);
    tick();

    p0 = pulses;
    access(1'b1, 32'h4000, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 1,
           st, a_s, we_s, wd_s);
    chk("b2b_ld_load", load_data, 32'hDEADBEEF);
    access(1'b0, 32'h4000, 4'b1111, 1'b0, 32'h11223344, 32'h0, 1,
           st, a_s, we_s, wd_s);
    chk("b2b_st_we", {28'd0, we_s}, 32'hF);
    chk("b2b_st_data", wd_s, 32'h11223344);
    chk("b2b_pulses", pulses - p0, 32'd2);

    p0 = pulses;
    mem_read_flag = 1'b1;
    mem_sel       = 4'b1111;
    mem_addr      = 32'h5000;
    ram_read_data = 32'hCAFEF00D;
    tick();
    tick();
    chk("abort_pre_en", {31'd0, ram_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_ram_en", {31'd0, ram_en}, 32'd0);
    chk("abort_stall", {31'd0, stall_request}, 32'd0);
    chk("abort_load", load_data, 32'h0);
    idle_inputs();
    #2;
    rst = 1'b0;
    tick();
    tick();
    chk("abort_no_retry", {31'd0, ram_en}, 32'd0);
    chk("abort_pulses", pulses - p0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
